// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush controller: stall vectors,
// hold-bit sense and flush sequencer state codes.
package pipe_stall_ctrl_pkg;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_FLUSH = 2'd2
  } flush_state_t;

  // Deepest requesting stage wins: it must also freeze everything upstream.
  function automatic logic [5:0] stall_encode(input logic req_if, input logic req_id,
                                              input logic req_ex, input logic req_mem);
    if (req_mem)     return STALL_MEM;
    else if (req_ex) return STALL_EX;
    else if (req_id) return STALL_ID;
    else if (req_if) return STALL_IF;
    else             return STALL_NONE;
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Stall/flush bundle between the pipeline stages (master) and the controller (slave).
interface pipe_stall_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             stallreq_if;
  logic             stallreq_id;
  logic             stallreq_ex;
  logic             stallreq_mem;
  logic             flush_req;
  logic [31:0]      flush_pc;
  logic [5:0]       stall;
  logic             flush;
  logic [31:0]      new_pc;
  logic [CNT_W-1:0] stall_cycles;
  logic             stall_timeout;

  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, flush_req, flush_pc,
    input  stall, flush, new_pc, stall_cycles, stall_timeout
  );

  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, flush_req, flush_pc,
    output stall, flush, new_pc, stall_cycles, stall_timeout
  );
endinterface

// File: rtl/pipe_stall_ctrl_watchdog.sv
// Stall debug counters: saturating total stall-cycle count and a sticky
// timeout once the pc stage has been held MAX_STALL consecutive cycles.
module pipe_stall_ctrl_watchdog
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MAX_STALL = 1024,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_pc,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             stall_timeout
);

  localparam int            CW    = $clog2(MAX_STALL + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_STALL);

  logic [CW-1:0]    consec_reg, consec_next;
  logic [CNT_W-1:0] cycles_reg, cycles_next;
  logic             timeout_reg, timeout_next;

  always_comb begin
    consec_next  = consec_reg;
    cycles_next  = cycles_reg;
    timeout_next = timeout_reg;
    if (stall_pc != STOP || flush)
      consec_next = '0;
    else if (consec_reg != MAX_C)
      consec_next = consec_reg + 1'b1;
    if (stall_pc == STOP && cycles_reg != '1)
      cycles_next = cycles_reg + 1'b1;
    if (consec_next == MAX_C)
      timeout_next = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      consec_reg  <= '0;
      cycles_reg  <= '0;
      timeout_reg <= 1'b0;
    end else begin
      consec_reg  <= consec_next;
      cycles_reg  <= cycles_next;
      timeout_reg <= timeout_next;
    end
  end

  assign stall_cycles  = cycles_reg;
  assign stall_timeout = timeout_reg;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline controller: merges stage stall requests into the hold vector and
// sequences exception flushes, deferring them while mem waits on the bus.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MAX_STALL = 1024,
  parameter int CNT_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  pipe_stall_ctrl_if.slave   bus
);

  flush_state_t state_reg, state_next;
  logic [31:0]  cap_pc_reg, cap_pc_next;
  logic [31:0]  new_pc_reg, new_pc_next;
  logic         flush_reg, flush_next;

  always_comb begin
    state_next  = state_reg;
    cap_pc_next = cap_pc_reg;
    new_pc_next = new_pc_reg;
    flush_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.flush_req) begin
          cap_pc_next = bus.flush_pc;
          if (!bus.stallreq_mem) begin
            state_next  = ST_FLUSH;
            flush_next  = 1'b1;
            new_pc_next = bus.flush_pc;
          end else begin
            state_next = ST_PEND;
          end
        end
      end
      // Later flush requests are dropped here: the first exception wins.
      ST_PEND: begin
        if (!bus.stallreq_mem) begin
          state_next  = ST_FLUSH;
          flush_next  = 1'b1;
          new_pc_next = cap_pc_reg;
        end
      end
      ST_FLUSH: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= ST_IDLE;
      cap_pc_reg <= '0;
      new_pc_reg <= '0;
      flush_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cap_pc_reg <= cap_pc_next;
      new_pc_reg <= new_pc_next;
      flush_reg  <= flush_next;
    end
  end

  // A flush wipes every pipeline register, so holding any stage is meaningless.
  assign bus.stall  = flush_reg ? {6{NO_STOP}}
                                : stall_encode(bus.stallreq_if, bus.stallreq_id,
                                               bus.stallreq_ex, bus.stallreq_mem);
  assign bus.flush  = flush_reg;
  assign bus.new_pc = new_pc_reg;

  pipe_stall_ctrl_watchdog #(
    .MAX_STALL (MAX_STALL),
    .CNT_W     (CNT_W)
  ) u_watchdog (
    .clk           (clk),
    .rst           (rst),
    .stall_pc      (bus.stall[0]),
    .flush         (flush_reg),
    .stall_cycles  (bus.stall_cycles),
    .stall_timeout (bus.stall_timeout)
  );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: a cycle-level reference model feeds
// expected stall vectors and flush targets into scoreboard queues.
module tb_pipe_stall_ctrl;

  localparam int MAX_STALL = 8;
  localparam int CNT_W     = 32;

  logic clk;
  logic rst;

  pipe_stall_ctrl_if #(.CNT_W(CNT_W)) bus();

  pipe_stall_ctrl #(
    .MAX_STALL (MAX_STALL),
    .CNT_W     (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [5:0]  stall_q[$];
  logic [31:0] flush_q[$];

  // Reference model state: 0 idle, 1 pending, 2 flushing
  int          m_state;
  logic        m_flush;
  logic [31:0] m_pc;
  logic [31:0] m_newpc;
  logic [31:0] m_cycles;
  int          m_consec;
  logic        m_timeout;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state   = 0;
    m_flush   = 1'b0;
    m_pc      = '0;
    m_newpc   = '0;
    m_cycles  = '0;
    m_consec  = 0;
    m_timeout = 1'b0;
    flush_q.delete();
    stall_q.delete();
  endtask

  // req = {mem, ex, id, if}. Called at posedge+1, returns at the next posedge+1.
  task automatic run_cycle(input logic [3:0] req, input logic fr, input logic [31:0] fpc);
    logic [5:0] exp_stall;
    bus.stallreq_if  = req[0];
    bus.stallreq_id  = req[1];
    bus.stallreq_ex  = req[2];
    bus.stallreq_mem = req[3];
    bus.flush_req    = fr;
    bus.flush_pc     = fpc;

    if (m_flush)     exp_stall = 6'b000000;
    else if (req[3]) exp_stall = 6'b011111;
    else if (req[2]) exp_stall = 6'b001111;
    else if (req[1]) exp_stall = 6'b000111;
    else if (req[0]) exp_stall = 6'b000011;
    else             exp_stall = 6'b000000;
    stall_q.push_back(exp_stall);

    #2;
    chk("stall", {26'd0, bus.stall}, {26'd0, stall_q.pop_front()});
    chk("flush", {31'd0, bus.flush}, {31'd0, m_flush});
    if (bus.flush) begin
      if (flush_q.size() > 0) chk("flush_new_pc", bus.new_pc, flush_q.pop_front());
      else                    chk("flush_unexpected", {31'd0, bus.flush}, 32'd0);
    end
    chk("new_pc_hold", bus.new_pc, m_newpc);
    chk("stall_cycles", bus.stall_cycles, m_cycles);
    chk("stall_timeout", {31'd0, bus.stall_timeout}, {31'd0, m_timeout});

    @(posedge clk);
    if (exp_stall[0] && m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 1;
    if (!exp_stall[0] || m_flush) m_consec = 0;
    else if (m_consec < MAX_STALL) m_consec++;
    if (m_consec == MAX_STALL) m_timeout = 1'b1;
    case (m_state)
      0: if (fr) begin
           m_pc = fpc;
           flush_q.push_back(fpc);
           m_state = req[3] ? 1 : 2;
         end
      1: if (!req[3]) m_state = 2;
      default: m_state = 0;
    endcase
    m_flush = (m_state == 2);
    if (m_flush) m_newpc = m_pc;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(4'b0000, 1'b0, 32'h0);
  endtask

  initial begin
    rst = 1'b0;
    bus.stallreq_if  = 1'b0;
    bus.stallreq_id  = 1'b0;
    bus.stallreq_ex  = 1'b0;
    bus.stallreq_mem = 1'b0;
    bus.flush_req    = 1'b0;
    bus.flush_pc     = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_flush", {31'd0, bus.flush}, 32'd0);
    chk("rst_new_pc", bus.new_pc, 32'd0);
    chk("rst_stall_cycles", bus.stall_cycles, 32'd0);
    chk("rst_timeout", {31'd0, bus.stall_timeout}, 32'd0);
    rst = 1'b1;

    // ex stall for three cycles
    for (int i = 0; i < 3; i++) run_cycle(4'b0100, 1'b0, 32'h0);
    chk("ex_stall_cycles", bus.stall_cycles, 32'd3);
    idle(1);

    // priority: mem beats if/id
    run_cycle(4'b1011, 1'b0, 32'h0);
    run_cycle(4'b0011, 1'b0, 32'h0);
    idle(1);

    // clean flush
    run_cycle(4'b0000, 1'b1, 32'h0000_0040);
    run_cycle(4'b0010, 1'b0, 32'h0);
    idle(2);

    // flush deferred by mem stall; second request ignored
    run_cycle(4'b1000, 1'b1, 32'h0000_0040);
    run_cycle(4'b1000, 1'b1, 32'h0000_0080);
    run_cycle(4'b1000, 1'b0, 32'h0);
    run_cycle(4'b1000, 1'b0, 32'h0);
    run_cycle(4'b0000, 1'b0, 32'h0);
    run_cycle(4'b0000, 1'b1, 32'h0000_00C0);
    idle(2);

    // two 7-cycle stalls separated by a gap: no timeout
    for (int i = 0; i < 7; i++) run_cycle(4'b0010, 1'b0, 32'h0);
    idle(1);
    for (int i = 0; i < 7; i++) run_cycle(4'b0010, 1'b0, 32'h0);
    idle(1);
    chk("timeout_7", {31'd0, bus.stall_timeout}, 32'd0);

    // 8-cycle stall: timeout is sticky
    for (int i = 0; i < 8; i++) run_cycle(4'b0010, 1'b0, 32'h0);
    chk("timeout_8", {31'd0, bus.stall_timeout}, 32'd1);
    idle(3);
    chk("timeout_sticky", {31'd0, bus.stall_timeout}, 32'd1);

    // reset while a flush is pending
    run_cycle(4'b1000, 1'b1, 32'h0000_0100);
    run_cycle(4'b1000, 1'b0, 32'h0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_flush", {31'd0, bus.flush}, 32'd0);
    chk("arst_new_pc", bus.new_pc, 32'd0);
    chk("arst_stall_cycles", bus.stall_cycles, 32'd0);
    chk("arst_timeout", {31'd0, bus.stall_timeout}, 32'd0);
    model_reset();
    bus.stallreq_mem = 1'b0;
    bus.flush_req    = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    run_cycle(4'b1000, 1'b0, 32'h0);
    run_cycle(4'b0001, 1'b0, 32'h0);
    idle(3);
    run_cycle(4'b0100, 1'b0, 32'h0);
    idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
